ascon_result_fifo: RTL and testbench
====================================

Name: ascon_result_fifo

Overview:
- Buffers 128-bit ciphertext/tag blocks produced by the Ascon core until the host drains them byte-by-byte over the register interface.
- It is the producer/responder end of the FIFO readout path: the core writes whole blocks, and the host reads REG_CRYPT_FIFO_CNT and REG_CRYPT_FIFO_DATA (16 bytes per block).
- It sits between the Ascon core output and the register front-end; it is single-clock.

Parameters:
- pDEPTH, 8, number of 128-bit entries (power of two, 2..128).
- pDATA_WIDTH, 128, block width in bits (multiple of 8).
- pCNT_WIDTH, 8, width of fifo_cnt; must hold the value pDEPTH.

Ports:
- clk  input  1  block clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush; resets pointers, count and sticky flags.
- wr_en  input  1  single-cycle push strobe from the core. No backpressure.
- wr_data  input  pDATA_WIDTH  block to push. Byte 0 is bits [127:120].
- rd_strobe  input  1  single-cycle host byte-read strobe.
- rd_byte_idx  input  4  byte offset within the head block (0..15).
- rd_data  output  8  registered read byte.
- rd_data_valid  output  1  pulses 1 cycle after rd_strobe.
- fifo_cnt  output  pCNT_WIDTH  number of stored blocks.
- empty  output  1  fifo_cnt==0.
- full  output  1  fifo_cnt==pDEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async) and clear (sync) set the following: wr_ptr=0, rd_ptr=0, fifo_cnt=0, empty=1, full=0, overflow=0, underflow=0, rd_data=0, rd_data_valid=0, state=IDLE. Storage contents are don't-care.
- clear has priority over wr_en and rd_strobe in the same cycle.
- Push: on wr_en & !full, store wr_data at wr_ptr and increment wr_ptr (mod pDEPTH). fifo_cnt is updated at the next edge.
- wr_en & full: the block is dropped and overflow is set. Storage and pointers are unchanged.
- Byte read: on rd_strobe & !empty, the next cycle gives rd_data = byte rd_byte_idx of the head entry (big-endian: idx 0 = MSB byte) and rd_data_valid=1.
- rd_strobe & empty: the next cycle gives rd_data=0x00, rd_data_valid=1, and underflow is set.
- State machine, IDLE and READING:
  - IDLE→READING: on rd_strobe with !empty and idx≠15.
  - READING stays READING on further reads with idx≠15.
  - Any state→IDLE: on rd_strobe with !empty and idx==15. This is a pop: rd_ptr increments and fifo_cnt decrements.
  - Bytes may be read in any order or repeated. Only the idx==15 read pops.
  - The idx==15 read returns the head byte before the pop takes effect.
- Simultaneous push and pop:
  - Not full: both occur and fifo_cnt is unchanged.
  - Full: the pop occurs and the push is dropped with overflow set, because full is evaluated on the pre-edge value.
  - Empty with pop-read: only the push occurs and underflow is set.
- The head entry is never modified while in READING; a concurrent push writes only to wr_ptr≠rd_ptr.
- fifo_cnt, empty and full are registered and consistent with each other every cycle.
- Pointers wrap mod pDEPTH; fifo_cnt saturates logically at pDEPTH, never pDEPTH+1.
- Latency:
  - Push to visible in fifo_cnt: 1 cycle.
  - Pop to fifo_cnt decrement: 1 cycle.
  - rd_strobe to rd_data: 1 cycle.
- Reset asserted mid-read returns to IDLE with the FIFO empty. The host must re-read fifo_cnt.

Test Plan:
- Reset, then push 0x8a278bf8fa2812bc39e52c76205af377 and read idx 0..15 → fifo_cnt goes 0→1. Bytes return 8a,27,8b,…,77 with rd_data_valid=1 each. After the idx 15 read, fifo_cnt=0 and empty=1.
- Push 10 distinct blocks with pDEPTH=8 → fifo_cnt=8, full=1, overflow=1. Draining returns blocks 0..7 in order, and blocks 8 and 9 are absent.
- Read idx 3 while empty → rd_data=0x00, underflow=1, fifo_cnt stays 0. clear then resets underflow=0.
- With fifo_cnt=8, push and pop (idx 15) in the same cycle → fifo_cnt=7 and overflow=1. With fifo_cnt=3, the same stimulus leaves fifo_cnt=3 and overflow unchanged.
- Read idx 15, then 0, then 15 of the head → the first idx 15 read pops. The idx 0 read returns the next block's MSB byte. Pointers wrap correctly across 20 push/pop cycles.
- Assert reset asynchronously mid-clock in READING with fifo_cnt=4 → all outputs are immediately at reset values and state=IDLE. A subsequent push/read works normally.

Source files
------------

// File: rtl/ascon_result_fifo.sv
// ---------------------------------------------------------------------------
// ascon_result_fifo
//
// Holds 128-bit ciphertext/tag blocks from the Ascon core until the host
// drains them one byte at a time through the register front-end. The core
// pushes whole blocks. The host reads any byte of the head block, in any
// order, and as often as it likes. Reading byte 15 pops the head block.
//
// Ports
//   clk            block clock
//   reset          asynchronous, active-high reset
//   clear          synchronous flush (pointers, count, sticky flags)
//   wr_en          single-cycle push strobe, no backpressure
//   wr_data        block to push; byte 0 is the MSB byte
//   rd_strobe      single-cycle host byte-read strobe
//   rd_byte_idx    byte offset within the head block (0..15)
//   rd_data        registered read byte
//   rd_data_valid  pulses one cycle after rd_strobe
//   fifo_cnt       number of stored blocks
//   empty / full   registered status, consistent with fifo_cnt
//   overflow       sticky: push attempted while full
//   underflow      sticky: read attempted while empty
// ---------------------------------------------------------------------------
module ascon_result_fifo #(
  parameter int pDEPTH      = 8,
  parameter int pDATA_WIDTH = 128,
  parameter int pCNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_strobe,
  input  logic [3:0]             rd_byte_idx,
  output logic [7:0]             rd_data,
  output logic                   rd_data_valid,
  output logic [pCNT_WIDTH-1:0]  fifo_cnt,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam int NB = pDATA_WIDTH / 8;

  typedef enum logic {IDLE, READING} state_t;

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  state_t                state_q, state_d;

  logic                   push_ok;
  logic                   pop;
  logic [pDATA_WIDTH-1:0] head;
  logic [7:0]             head_bytes [16];

  // Full/empty are judged on the pre-edge registered values, so a push into
  // a full FIFO is dropped even if the same cycle pops.
  assign push_ok = wr_en & ~full_q;
  assign pop     = rd_strobe & ~empty_q & (rd_byte_idx == 4'd15);

  assign head = mem[rd_ptr_q];

  // Big-endian byte view of the head block; byte 0 is the MSB byte.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_head_bytes
      if (gi < NB) begin : g_byte
        assign head_bytes[gi] = head[pDATA_WIDTH-1-8*gi -: 8];
      end else begin : g_pad
        assign head_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    state_d    = state_q;

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      rd_data_d = 8'h00;
      state_d   = IDLE;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (wr_en && full_q) begin
        ovf_d = 1'b1;
      end

      if (rd_strobe) begin
        rd_valid_d = 1'b1;
        if (empty_q) begin
          rd_data_d = 8'h00;
          unf_d     = 1'b1;
        end else begin
          // Byte 15 returns the head byte before the pop takes effect.
          rd_data_d = head_bytes[rd_byte_idx];
          state_d   = (rd_byte_idx == 4'd15) ? IDLE : READING;
        end
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + pCNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - pCNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == pCNT_WIDTH'(pDEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      state_q    <= state_d;
    end
  end

  // Storage has no reset. A push never lands on the head entry while it
  // holds data, because wr_ptr only equals rd_ptr when the FIFO is empty
  // or full, and a full FIFO refuses the push.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign fifo_cnt      = cnt_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_ascon_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_ascon_result_fifo
//
// Directed bench for ascon_result_fifo. Inputs change on the falling edge.
// Registered outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_ascon_result_fifo;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         wr_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic         rd_strobe = 1'b0;
  logic [3:0]   rd_byte_idx = 4'd0;
  logic [7:0]   rd_data;
  logic         rd_data_valid;
  logic [7:0]   fifo_cnt;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ascon_result_fifo #(
    .pDEPTH(8),
    .pDATA_WIDTH(128),
    .pCNT_WIDTH(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_strobe    (rd_strobe),
    .rd_byte_idx  (rd_byte_idx),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .fifo_cnt     (fifo_cnt),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Block i: byte k holds {i, k}, so every byte of every block is distinct.
  function automatic logic [127:0] mk(input logic [3:0] i);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[127-8*k -: 8] = {i, 4'(k)};
    end
    return r;
  endfunction

  task automatic push(input logic [127:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rd_strobe   = 1'b1;
    rd_byte_idx = idx;
    @(negedge clk);
    rd_strobe   = 1'b0;
    check_eq({tag, ".data"}, 128'(rd_data), 128'(exp));
    check_eq({tag, ".valid"}, 128'(rd_data_valid), 128'd1);
  endtask

  task automatic push_pop(input string tag, input logic [127:0] d, input logic [7:0] exp);
    @(negedge clk);
    wr_en       = 1'b1;
    wr_data     = d;
    rd_strobe   = 1'b1;
    rd_byte_idx = 4'd15;
    @(negedge clk);
    wr_en       = 1'b0;
    rd_strobe   = 1'b0;
    check_eq({tag, ".data"}, 128'(rd_data), 128'(exp));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [7:0] exp_a [16] = '{8'h8a, 8'h27, 8'h8b, 8'hf8, 8'hfa, 8'h28, 8'h12, 8'hbc,
                             8'h39, 8'he5, 8'h2c, 8'h76, 8'h20, 8'h5a, 8'hf3, 8'h77};

  initial begin
    // ---------------- reset state ----------------
    #12;
    check_eq("rst.cnt", 128'(fifo_cnt), 128'd0);
    check_eq("rst.empty", 128'(empty), 128'd1);
    check_eq("rst.full", 128'(full), 128'd0);
    check_eq("rst.valid", 128'(rd_data_valid), 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- single block, all 16 bytes ----------------
    push(128'h8a278bf8fa2812bc39e52c76205af377);
    check_eq("t1.cnt1", 128'(fifo_cnt), 128'd1);
    check_eq("t1.empty0", 128'(empty), 128'd0);
    for (int k = 0; k < 16; k++) begin
      rd($sformatf("t1.b%0d", k), 4'(k), exp_a[k]);
    end
    check_eq("t1.cnt0", 128'(fifo_cnt), 128'd0);
    check_eq("t1.empty1", 128'(empty), 128'd1);
    @(negedge clk);
    check_eq("t1.valid_drop", 128'(rd_data_valid), 128'd0);

    // ---------------- overfill with 10 blocks ----------------
    for (int i = 0; i < 10; i++) push(mk(4'(i)));
    check_eq("t2.cnt", 128'(fifo_cnt), 128'd8);
    check_eq("t2.full", 128'(full), 128'd1);
    check_eq("t2.ovf", 128'(overflow), 128'd1);
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("t2.blk%0d.b0", i), 4'd0, {4'(i), 4'h0});
      rd($sformatf("t2.blk%0d.b15", i), 4'd15, {4'(i), 4'hf});
    end
    check_eq("t2.drained_cnt", 128'(fifo_cnt), 128'd0);
    check_eq("t2.drained_empty", 128'(empty), 128'd1);
    check_eq("t2.ovf_sticky", 128'(overflow), 128'd1);

    // ---------------- underflow ----------------
    rd("t3.empty_rd", 4'd3, 8'h00);
    check_eq("t3.unf", 128'(underflow), 128'd1);
    check_eq("t3.cnt", 128'(fifo_cnt), 128'd0);
    do_clear();
    check_eq("t3.clr_unf", 128'(underflow), 128'd0);
    check_eq("t3.clr_ovf", 128'(overflow), 128'd0);

    // ---------------- push + pop at full and at 3 ----------------
    for (int i = 0; i < 8; i++) push(mk(4'(i)));
    check_eq("t4.full", 128'(full), 128'd1);
    push_pop("t4.full_pp", mk(4'd12), 8'h0f);
    check_eq("t4.cnt7", 128'(fifo_cnt), 128'd7);
    check_eq("t4.ovf", 128'(overflow), 128'd1);
    check_eq("t4.full0", 128'(full), 128'd0);
    do_clear();
    for (int i = 0; i < 3; i++) push(mk(4'(i + 4)));
    push_pop("t4.three_pp", mk(4'd13), 8'h4f);
    check_eq("t4.cnt3", 128'(fifo_cnt), 128'd3);
    check_eq("t4.ovf0", 128'(overflow), 128'd0);
    rd("t4.next_head", 4'd0, 8'h50);

    // ---------------- pop order and pointer wrap ----------------
    do_clear();
    push(mk(4'd1));
    push(mk(4'd2));
    rd("t5.pop1", 4'd15, 8'h1f);
    check_eq("t5.cnt1", 128'(fifo_cnt), 128'd1);
    rd("t5.next_msb", 4'd0, 8'h20);
    rd("t5.pop2", 4'd15, 8'h2f);
    check_eq("t5.empty", 128'(empty), 128'd1);
    for (int j = 0; j < 20; j++) begin
      push(mk(4'(j)));
      rd($sformatf("t5.w%0d.b7", j), 4'd7, {4'(j), 4'h7});
      rd($sformatf("t5.w%0d.b15", j), 4'd15, {4'(j), 4'hf});
    end
    check_eq("t5.wrap_empty", 128'(empty), 128'd1);

    // ---------------- async reset mid-read ----------------
    for (int i = 0; i < 4; i++) push(mk(4'(i + 8)));
    check_eq("t6.cnt4", 128'(fifo_cnt), 128'd4);
    rd("t6.reading", 4'd2, 8'h82);
    #1 reset = 1'b1;
    #1;
    check_eq("t6.cnt", 128'(fifo_cnt), 128'd0);
    check_eq("t6.empty", 128'(empty), 128'd1);
    check_eq("t6.valid", 128'(rd_data_valid), 128'd0);
    check_eq("t6.data", 128'(rd_data), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    push(mk(4'd9));
    check_eq("t6.post_cnt", 128'(fifo_cnt), 128'd1);
    rd("t6.post_rd", 4'd15, 8'h9f);
    check_eq("t6.post_empty", 128'(empty), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
